// File: rtl/pulse_period_meter.sv
// pulse_period_meter
// Measures the clock-cycle interval between accepted rising edges of a clean,
// clk-synchronous sensor level. Publishes the interval with a one-cycle valid
// strobe, counts revolutions, rejects edges closer than MIN_PERIOD and declares
// the wheel stopped when no accepted edge arrives within TIMEOUT cycles.
module pulse_period_meter #(
    parameter int CNT_BITS   = 24,
    parameter int MIN_PERIOD = 1000,
    parameter int TIMEOUT    = 12500000,
    parameter int REV_BITS   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pulse_in,
    input  logic                clear_revs,
    output logic [CNT_BITS-1:0] period,
    output logic                period_valid,
    output logic                stopped,
    output logic [REV_BITS-1:0] rev_count
);

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_MEASURE = 1'b1;

    localparam logic [CNT_BITS-1:0] MIN_C   = CNT_BITS'(MIN_PERIOD);
    localparam logic [CNT_BITS-1:0] TMO_C   = CNT_BITS'(TIMEOUT);
    localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

    logic [0:0]          r_state;
    logic [CNT_BITS-1:0] r_cnt;
    logic                r_prev;
    logic [CNT_BITS-1:0] r_period;
    logic                r_valid;
    logic                r_stopped;
    logic [REV_BITS-1:0] r_rev;

    logic w_rise;
    logic w_first;
    logic w_accept;
    logic w_timeout;
    logic w_rev_inc;

    // prev resets to 1 so a level already high at reset release is not an edge
    assign w_rise    = pulse_in & ~r_prev;
    assign w_first   = (r_state == S_IDLE) && w_rise;
    assign w_accept  = (r_state == S_MEASURE) && w_rise && (r_cnt >= MIN_C);
    // a rise at cnt == TIMEOUT is always accepted (TIMEOUT >= MIN_PERIOD),
    // so the timeout only fires when no rise is present
    assign w_timeout = (r_state == S_MEASURE) && !w_rise && (r_cnt == TMO_C);
    assign w_rev_inc = w_first | w_accept;

    // Edge detector, interval counter, period capture and stop detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_prev    <= 1'b1;
            r_period  <= '0;
            r_valid   <= 1'b0;
            r_stopped <= 1'b1;
        end else begin
            r_prev  <= pulse_in;
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // one edge gives no interval: outputs untouched here
                    if (w_rise) begin
                        r_cnt   <= CNT_ONE;
                        r_state <= S_MEASURE;
                    end else begin
                        r_cnt <= '0;
                    end
                end
                S_MEASURE: begin
                    if (w_accept) begin
                        r_period  <= r_cnt;
                        r_valid   <= 1'b1;
                        r_stopped <= 1'b0;
                        r_cnt     <= CNT_ONE;
                    end else if (w_timeout) begin
                        r_period  <= '0;
                        r_stopped <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= S_IDLE;
                    end else begin
                        // glitch edges fall through here and keep counting
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Revolution counter: clear wins over the old value, but a coincident
    // accepted edge still counts as the first revolution after the clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rev <= '0;
        end else if (clear_revs) begin
            r_rev <= w_rev_inc ? REV_BITS'(1) : '0;
        end else if (w_rev_inc) begin
            r_rev <= r_rev + REV_BITS'(1);
        end
    end

    assign period       = r_period;
    assign period_valid = r_valid;
    assign stopped      = r_stopped;
    assign rev_count    = r_rev;

endmodule
